taxel_frame_scanner: RTL and testbench
======================================

// Module: taxel_frame_scanner
// PURPOSE
//  Scans one frame of tactile-array pressure samples from a synchronous frame RAM and emits,
//  per taxel at/above threshold, its 1-based (x,y) coordinate with a valid strobe; then pulses
//  tabulate once per frame. It is the transmitter feeding center_of_mass (x_in/y_in/valid_in/
//  tabulate_in), and it holds off the next frame until the centroid result returns.
// PARAMETERS
//  COLS          64    taxel columns per row (1..2047)
//  ROWS          48    taxel rows per frame (1..1023)
//  DATA_W        12    pressure sample width
//  ADDR_W        16    frame RAM address width; COLS*ROWS <= 2**ADDR_W
//  READ_LAT      2     frame RAM read latency in cycles (>=1)
//  DONE_TIMEOUT  4096  max cycles waiting for com_done_in
// PORTS
//  clk_in        in   1       system clock
//  rst_in        in   1       asynchronous, active-high reset
//  start_in      in   1       1-cycle frame start request
//  threshold_in  in   DATA_W  hit threshold, sampled on accepted start
//  rd_en_out     out  1       frame RAM read enable
//  rd_addr_out   out  ADDR_W  frame RAM address, row*COLS+col
//  rd_data_in    in   DATA_W  RAM data, valid READ_LAT cycles after rd_en_out
//  x_out         out  11      hit column + 1 (to center_of_mass x_in)
//  y_out         out  10      hit row + 1 (to center_of_mass y_in)
//  valid_out     out  1       hit strobe (to valid_in)
//  tabulate_out  out  1       1-cycle end-of-frame pulse (to tabulate_in)
//  com_done_in   in   1       center_of_mass valid_out
//  busy_out      out  1       high in any state but IDLE
//  hit_count_out out  16      hits in last completed frame, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0; counters, threshold and pipeline cleared;
//   an in-flight frame is abandoned, no tabulate is issued.
//  States: IDLE -> SCAN -> DRAIN -> TAB -> WAIT_DONE -> IDLE.
//  IDLE: start_in=1 latches threshold_in, zeroes running hit counter, col=row=0 -> SCAN.
//   start_in outside IDLE is ignored (no queueing).
//  SCAN: rd_en_out=1 every cycle, address increments by 1 starting at 0; col wraps COLS-1->0 and
//   increments row. Issuing address COLS*ROWS-1 moves to DRAIN. Exactly COLS*ROWS reads per frame.
//  Pipeline: (col,row,rd_en) delayed READ_LAT stages alongside the RAM. At the cycle data returns,
//   hit = rd_data_in >= threshold (unsigned); registered next cycle: valid_out=hit,
//   x_out=col+1, y_out=row+1. Read->valid_out latency = READ_LAT+1 cycles. 1-based coordinates
//   because the consumer discards zero coordinates.
//  x_out/y_out hold last hit values when valid_out=0.
//  DRAIN: rd_en_out=0; waits until last sample's valid_out slot has occurred -> TAB.
//  TAB: tabulate_out=1 for exactly one cycle, valid_out=0 in that cycle and the cycle before it
//   is the last valid slot; hit_count_out updated here. Next state WAIT_DONE if hits>0, else IDLE
//   (consumer never divides on an empty frame).
//  WAIT_DONE: exits to IDLE on com_done_in=1 or after DONE_TIMEOUT cycles, whichever first;
//   com_done_in in any other state is ignored.
//  Hit counter: +1 per valid_out, saturating; never wraps.
//  Threshold 0: every taxel is a hit. All-max threshold: only samples equal to max are hits.
//  Frame period (no timeout) = COLS*ROWS + READ_LAT + 3 cycles + wait for com_done_in.
// TESTING
//  COLS=4,ROWS=3,READ_LAT=2, RAM all 0 except addr 5=100, thr=50, start -> one valid_out with
//   x=2,y=2 exactly 3 cycles after addr 5 read; tabulate 1 cycle after last slot; hit_count=1.
//  Same RAM, thr=0 -> 12 valid_out pulses, x cycles 1..4, y 1..3 in raster order; hit_count=12.
//  thr=4095, RAM all 0 -> no valid_out, tabulate once, returns IDLE next cycle, busy_out low.
//  One hit, com_done_in never asserted, DONE_TIMEOUT=16 -> busy_out falls 16 cycles after TAB;
//   repeat with com_done_in at cycle 5 -> IDLE next cycle.
//  start_in pulsed mid-SCAN and threshold_in changed -> ignored, hits use latched threshold.
//  rst_in asserted mid-SCAN -> all outputs 0 immediately; no tabulate; fresh start works normally.

Source files
------------

// File: rtl/taxel_frame_scanner.sv
// Tactile frame scanner: raster-reads a frame RAM, emits 1-based hit
// coordinates, pulses tabulate per frame, then waits for the centroid.
module taxel_frame_scanner #(
    parameter int COLS         = 64,
    parameter int ROWS         = 48,
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 16,
    parameter int READ_LAT     = 2,
    parameter int DONE_TIMEOUT = 4096
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              start_in,
    input  logic [DATA_W-1:0] threshold_in,
    output logic              rd_en_out,
    output logic [ADDR_W-1:0] rd_addr_out,
    input  logic [DATA_W-1:0] rd_data_in,
    output logic [10:0]       x_out,
    output logic [9:0]        y_out,
    output logic              valid_out,
    output logic              tabulate_out,
    input  logic              com_done_in,
    output logic              busy_out,
    output logic [15:0]       hit_count_out
);

    localparam int NPIX  = COLS * ROWS;
    localparam int CMAX  = (DONE_TIMEOUT > READ_LAT) ? DONE_TIMEOUT : READ_LAT;
    localparam int CNT_W = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE, SCAN, DRAIN, TAB, WAIT_DONE
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0]           thr;
    logic [10:0]                 col;
    logic [9:0]                  row;
    logic [CNT_W-1:0]            cnt;
    logic [15:0]                 hits;
    logic [READ_LAT-1:0]         pen;
    logic [READ_LAT-1:0][10:0]   pcol;
    logic [READ_LAT-1:0][9:0]    prow;
    logic                        last_rd;
    logic                        hit;
    logic                        start_ok;

    assign last_rd  = (rd_addr_out == ADDR_W'(NPIX - 1));
    assign hit      = pen[READ_LAT-1] && (rd_data_in >= thr);
    assign start_ok = (state == IDLE) && start_in;

    // State register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state and state-decoded outputs
    always_comb begin
        state_nx     = state;
        rd_en_out    = 1'b0;
        tabulate_out = 1'b0;
        busy_out     = 1'b1;
        unique case (state)
            IDLE: begin
                busy_out = 1'b0;
                if (start_in) state_nx = SCAN;
            end
            SCAN: begin
                rd_en_out = 1'b1;
                if (last_rd) state_nx = DRAIN;
            end
            DRAIN: begin
                if (cnt == CNT_W'(READ_LAT)) state_nx = TAB;
            end
            TAB: begin
                tabulate_out = 1'b1;
                state_nx     = (hits != 16'd0) ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                if (com_done_in || cnt == CNT_W'(DONE_TIMEOUT - 1))
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Drain / timeout counter, restarted on every state change
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)                 cnt <= '0;
        else if (state != state_nx) cnt <= '0;
        else                        cnt <= cnt + 1'b1;
    end

    // Threshold latch and raster address generation
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            thr         <= '0;
            rd_addr_out <= '0;
            col         <= '0;
            row         <= '0;
        end else if (start_ok) begin
            thr         <= threshold_in;
            rd_addr_out <= '0;
            col         <= '0;
            row         <= '0;
        end else if (state == SCAN) begin
            if (last_rd) begin
                rd_addr_out <= '0;
                col         <= '0;
                row         <= '0;
            end else if (col == 11'(COLS - 1)) begin
                rd_addr_out <= rd_addr_out + 1'b1;
                col         <= '0;
                row         <= row + 1'b1;
            end else begin
                rd_addr_out <= rd_addr_out + 1'b1;
                col         <= col + 1'b1;
            end
        end
    end

    // Coordinate/enable pipeline matching the RAM read latency
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pen  <= '0;
            pcol <= '0;
            prow <= '0;
        end else begin
            pen[0]  <= (state == SCAN);
            pcol[0] <= col;
            prow[0] <= row;
            for (int i = 1; i < READ_LAT; i++) begin
                pen[i]  <= pen[i-1];
                pcol[i] <= pcol[i-1];
                prow[i] <= prow[i-1];
            end
        end
    end

    // Hit output register; coordinates hold between hits
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
        end else begin
            valid_out <= hit;
            if (hit) begin
                x_out <= pcol[READ_LAT-1] + 11'd1;
                y_out <= prow[READ_LAT-1] + 10'd1;
            end
        end
    end

    // Running and reported hit counts, saturating
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hits          <= '0;
            hit_count_out <= '0;
        end else begin
            if (start_ok)
                hits <= '0;
            else if (hit && hits != 16'hFFFF)
                hits <= hits + 16'd1;
            if (state == TAB)
                hit_count_out <= hits;
        end
    end

endmodule

// File: tb/tb_taxel_frame_scanner.sv
// Self-checking bench for taxel_frame_scanner: table vectors, corner
// sequences and random frames against a per-cycle reference model.
module tb_taxel_frame_scanner;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int RL   = 2;
    localparam int DT   = 16;
    localparam int DW   = 12;
    localparam int AW   = 16;
    localparam int N    = COLS * ROWS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] threshold;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [10:0]   x;
    logic [9:0]    y;
    logic          valid;
    logic          tab;
    logic          com_done;
    logic          busy;
    logic [15:0]   hit_count;

    taxel_frame_scanner #(
        .COLS(COLS), .ROWS(ROWS), .DATA_W(DW), .ADDR_W(AW),
        .READ_LAT(RL), .DONE_TIMEOUT(DT)
    ) dut (
        .clk_in(clk), .rst_in(rst), .start_in(start),
        .threshold_in(threshold), .rd_en_out(rd_en),
        .rd_addr_out(rd_addr), .rd_data_in(rd_data),
        .x_out(x), .y_out(y), .valid_out(valid),
        .tabulate_out(tab), .com_done_in(com_done),
        .busy_out(busy), .hit_count_out(hit_count)
    );

    always #5 clk = ~clk;

    // Frame RAM with RL-cycle read latency
    logic [DW-1:0] ram  [N];
    logic [DW-1:0] pipe [RL];

    always @(posedge clk) begin
        pipe[0] <= (rd_en && int'(rd_addr) < N) ? ram[int'(rd_addr)] : '0;
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RL-1];

    int passed = 0;
    int total  = 0;
    int lastx  = 0;
    int lasty  = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic fill(input int mode);
        for (int a = 0; a < N; a++) begin
            case (mode)
                0: ram[a] = (a == 5) ? DW'(100) : '0;
                1: ram[a] = '1;
                2: ram[a] = DW'(a * 300);
                3: ram[a] = '0;
                default: ram[a] = DW'($urandom_range(0, 4095));
            endcase
        end
    endtask

    function automatic int model_hits(input int thr);
        int c = 0;
        for (int a = 0; a < N; a++) if (int'(ram[a]) >= thr) c++;
        return c;
    endfunction

    // Runs one frame from IDLE, checking every cycle against the model.
    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_frame(input int thr, input int d, input bit glitch,
                             input int exp_hits, input int abort_at);
        int tcyc, fin, a, pulses;
        bit ev;
        tcyc   = N + RL + 1;
        pulses = 0;
        if (exp_hits == 0)         fin = tcyc + 1;
        else if (d >= 0 && d < DT) fin = tcyc + 2 + d;
        else                       fin = tcyc + 1 + DT;
        start     = 1'b1;
        threshold = DW'(thr);
        @(posedge clk); #1;
        start     = 1'b0;
        threshold = DW'($urandom_range(0, 4095));
        for (int k = 0; k <= fin; k++) begin
            if (k == abort_at) return;
            com_done = (d >= 0 && k == tcyc + 1 + d);
            start    = glitch && (k == 3);
            if (glitch && k == 3) threshold = '0;
            @(negedge clk);
            a  = k - RL - 1;
            ev = 1'b0;
            if (a >= 0 && a < N) ev = (int'(ram[a]) >= thr);
            chk("rd_en", int'(rd_en), int'(k < N));
            if (k < N) chk("rd_addr", int'(rd_addr), k);
            chk("valid", int'(valid), int'(ev));
            if (ev) begin
                lastx = a % COLS + 1;
                lasty = a / COLS + 1;
            end
            pulses += int'(valid);
            chk("x", int'(x), lastx);
            chk("y", int'(y), lasty);
            chk("tabulate", int'(tab), int'(k == tcyc));
            chk("busy", int'(busy), int'(k < fin));
            @(posedge clk); #1;
        end
        com_done = 1'b0;
        start    = 1'b0;
        chk("hit_count", int'(hit_count), exp_hits);
        chk("pulses", pulses, exp_hits);
    endtask

    typedef struct {
        int fill;
        int thr;
        int d;
        bit glitch;
        int hits;
    } vec_t;

    vec_t tbl [11];

    initial begin
        tbl[0]  = '{0,   50,  2, 1'b0,  1};
        tbl[1]  = '{0,    0,  0, 1'b0, 12};
        tbl[2]  = '{3, 4095,  0, 1'b0,  0};
        tbl[3]  = '{0,   50, -1, 1'b0,  1};
        tbl[4]  = '{0,   50,  5, 1'b0,  1};
        tbl[5]  = '{0,   50,  3, 1'b1,  1};
        tbl[6]  = '{1, 4095, -1, 1'b0, 12};
        tbl[7]  = '{2,  300,  4, 1'b0, 11};
        tbl[8]  = '{2, 3300,  1, 1'b0,  1};
        tbl[9]  = '{2, 3301,  0, 1'b0,  0};
        tbl[10] = '{0,  101,  0, 1'b0,  0};

        rst       = 1'b1;
        start     = 1'b0;
        threshold = '0;
        com_done  = 1'b0;
        fill(3);
        for (int i = 0; i < RL; i++) pipe[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_addr", int'(rd_addr), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_tab", int'(tab), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_hit_count", int'(hit_count), 0);
        chk("rst_xy", int'(x) + int'(y), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            fill(tbl[i].fill);
            run_frame(tbl[i].thr, tbl[i].d, tbl[i].glitch, tbl[i].hits, -1);
        end

        // Reset in the middle of a scan
        fill(1);
        run_frame(0, 0, 1'b0, N, 5);
        rst = 1'b1;
        #1;
        chk("mid_rst_rd_en", int'(rd_en), 0);
        chk("mid_rst_addr", int'(rd_addr), 0);
        chk("mid_rst_valid", int'(valid), 0);
        chk("mid_rst_xy", int'(x) + int'(y), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_hit_count", int'(hit_count), 0);
        lastx = 0;
        lasty = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_tab", int'(tab), 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("post_rst_tab", int'(tab), 0);
            chk("post_rst_busy", int'(busy), 0);
        end
        @(posedge clk); #1;
        fill(0);
        run_frame(50, 1, 1'b0, 1, -1);

        // Random frames against the model
        for (int r = 0; r < 20; r++) begin
            int thr, d;
            fill(4);
            thr = int'($urandom_range(0, 4095));
            d   = int'($urandom_range(0, 20));
            run_frame(thr, d, r[0], model_hits(thr), -1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
